vga_timing_gen: RTL

- Raster timing generator and pixel output stage for the VGA peripheral.
- Produces frame-buffer read coordinates (h_addr/v_addr), takes back the 24-bit pixel word, and drives registered RGB, hsync, vsync and valid to the pad/display model.
- Default timing is 640x480@60.
- Sits directly downstream of the APB frame buffer. All outputs are registered and aligned to each other.

---
 rtl/vga_timing_gen.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator and pixel output stage for the VGA peripheral.
// Free-running horizontal/vertical counters produce frame-buffer read
// coordinates. The returned 24-bit pixel word is registered together with
// hsync, vsync, valid and frame_start, so all pad-side outputs change on the
// same clock edge. The default parameters give 640x480@60.
//
// Optional feature (macro VGA_TEST_PATTERN_EN):
//   When defined, test_en=1 replaces vga_data at the output register with
//   eight vertical colour bars. Timing, addresses and sync are unchanged.
//   When undefined, test_en is ignored and no pattern logic exists.
//
// Ports:
//   clock        in   1   pixel clock
//   reset        in   1   synchronous, active-high
//   h_addr       out  10  pixel column to fetch (0 outside the active region)
//   v_addr       out  10  pixel row to fetch (0 outside the active region)
//   vga_data     in   24  pixel word {R,G,B} for the issued address
//   test_en      in   1   colour-bar select (VGA_TEST_PATTERN_EN builds only)
//   frame_start  out  1   one-cycle pulse, DATA_LAT+1 cycles after the origin
//   hsync        out  1   horizontal sync, active-low
//   vsync        out  1   vertical sync, active-low
//   valid        out  1   RGB carries a visible pixel
//   vga_r/g/b    out  8   colour channels
//
// DATA_LAT is the read latency of the frame buffer: 0 for a combinational
// read, 1 for a registered read. The sync/blank controls are delayed by the
// same amount so that they stay aligned with the returned pixel data.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int DATA_LAT = 0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    input  logic [23:0] vga_data,
    input  logic        test_en,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        valid,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Region boundaries are held one bit wider than the counters so that a
    // boundary equal to 1024 still compares correctly.
    localparam logic [10:0] H_ACT_X     = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT_X     = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);

    // Elaboration-time parameter sanity check; carries no hardware.
    initial begin
        assert (H_TOTAL <= 1024 && V_TOTAL <= 1024)
            else $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counters");
        assert (DATA_LAT == 0 || DATA_LAT == 1)
            else $error("vga_timing_gen: DATA_LAT must be 0 or 1");
    end

`ifdef VGA_TEST_PATTERN_EN
    // Eight equal-width vertical bars across the active columns.
    function automatic logic [23:0] bar_colour(input logic [9:0] col);
        logic [31:0] idx;
        idx = ({22'd0, col} * 32'd8) / 32'(H_ACTIVE);
        case (idx)
            32'd0:   bar_colour = 24'hFFFFFF;  // white
            32'd1:   bar_colour = 24'hFFFF00;  // yellow
            32'd2:   bar_colour = 24'h00FFFF;  // cyan
            32'd3:   bar_colour = 24'h00FF00;  // green
            32'd4:   bar_colour = 24'hFF00FF;  // magenta
            32'd5:   bar_colour = 24'hFF0000;  // red
            32'd6:   bar_colour = 24'h0000FF;  // blue
            default: bar_colour = 24'h000000;  // black
        endcase
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Raster counters
    // -------------------------------------------------------------------------
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       h_wrap;
    logic       started_q;

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
            started_q <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            // Masks the origin pulse for the first cycle after reset so that
            // frame_start first fires one full frame after release.
            started_q <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 0: region decode and read addresses
    // -------------------------------------------------------------------------
    logic       h_act_p0, v_act_p0;
    logic       disp_p0, hs_p0, vs_p0, org_p0;
    logic [9:0] col_p0;

    always_comb begin
        h_act_p0 = ({1'b0, h_cnt_q} < H_ACT_X);
        v_act_p0 = ({1'b0, v_cnt_q} < V_ACT_X);
        disp_p0  = h_act_p0 && v_act_p0;
        hs_p0    = ~(({1'b0, h_cnt_q} >= H_SYNC_BEG) && ({1'b0, h_cnt_q} < H_SYNC_END));
        vs_p0    = ~(({1'b0, v_cnt_q} >= V_SYNC_BEG) && ({1'b0, v_cnt_q} < V_SYNC_END));
        org_p0   = started_q && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        col_p0   = h_cnt_q;
    end

    assign h_addr = disp_p0 ? h_cnt_q : 10'd0;
    assign v_addr = disp_p0 ? v_cnt_q : 10'd0;

    // -------------------------------------------------------------------------
    // Stage 1 (DATA_LAT=1 only): match the frame-buffer read register
    // -------------------------------------------------------------------------
    logic       disp_dl, hs_dl, vs_dl, org_dl;
    logic [9:0] col_dl;

    if (DATA_LAT == 1) begin : g_lat1
        logic       disp_p1_q, hs_p1_q, vs_p1_q, org_p1_q;
        logic [9:0] col_p1_q;

        // Syncs idle high in this stage so no false pulse appears after reset.
        always_ff @(posedge clock) begin
            if (reset) begin
                disp_p1_q <= 1'b0;
                hs_p1_q   <= 1'b1;
                vs_p1_q   <= 1'b1;
                org_p1_q  <= 1'b0;
                col_p1_q  <= 10'd0;
            end else begin
                disp_p1_q <= disp_p0;
                hs_p1_q   <= hs_p0;
                vs_p1_q   <= vs_p0;
                org_p1_q  <= org_p0;
                col_p1_q  <= col_p0;
            end
        end

        assign disp_dl = disp_p1_q;
        assign hs_dl   = hs_p1_q;
        assign vs_dl   = vs_p1_q;
        assign org_dl  = org_p1_q;
        assign col_dl  = col_p1_q;
    end else begin : g_lat0
        assign disp_dl = disp_p0;
        assign hs_dl   = hs_p0;
        assign vs_dl   = vs_p0;
        assign org_dl  = org_p0;
        assign col_dl  = col_p0;
    end

    // -------------------------------------------------------------------------
    // Output register: RGB, valid, syncs and frame_start share one edge
    // -------------------------------------------------------------------------
    logic [23:0] rgb_q, rgb_d;
    logic        valid_q, hsync_q, vsync_q, fstart_q;

`ifdef VGA_TEST_PATTERN_EN
    always_comb begin
        rgb_d = 24'd0;
        if (disp_dl) begin
            rgb_d = test_en ? bar_colour(col_dl) : vga_data;
        end
    end
`else
    // Pattern select and column are not needed in this build.
    logic unused_pattern;
    assign unused_pattern = ^{test_en, col_dl};

    always_comb begin
        rgb_d = 24'd0;
        if (disp_dl) begin
            rgb_d = vga_data;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_q    <= 24'd0;
            valid_q  <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            fstart_q <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            valid_q  <= disp_dl;
            hsync_q  <= hs_dl;
            vsync_q  <= vs_dl;
            fstart_q <= org_dl;
        end
    end

    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign valid       = valid_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fstart_q;

endmodule
